// File: rtl/qpsk_pkg.sv
// qpsk_pkg: types and constants shared by the QPSK NCO scheduler and demodulator.
//   state_t      scheduler FSM states
//   QPSK_APRP    phase-modulation width of the carrier NCO
//   QPSK_PHASE_OFS constellation rotation (pi/4 at 14 bits)
//   gray_decode  dibit -> quadrant index
package qpsk_pkg;

    localparam int unsigned QPSK_APRP = 14;
    localparam logic [QPSK_APRP-1:0] QPSK_PHASE_OFS = 14'h0800;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Gray decode: 00->0, 01->1, 11->2, 10->3
    function automatic logic [1:0] gray_decode(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

endpackage

// File: rtl/qpsk_sym_skid.sv
// qpsk_sym_skid: one-entry symbol holding register with bypass.
//   clk, reset         clock, async active-high reset
//   in_valid/in_data   symbol offered by the packer
//   in_ready           slot empty, symbol can be accepted
//   take               consumer uses out_data this cycle
//   held               a symbol is sitting in the slot
//   out_valid/out_data slot contents, or the incoming symbol when the slot is empty
module qpsk_sym_skid (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [1:0] in_data,
    output logic       in_ready,
    input  logic       take,
    output logic       held,
    output logic       out_valid,
    output logic [1:0] out_data
);

    logic       nxt_v;
    logic [1:0] nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nxt_v <= 1'b0;
            nxt   <= 2'b00;
        end else if (nxt_v) begin
            if (take) begin
                nxt_v <= 1'b0;
            end
        end else if (in_valid && !take) begin
            // An incoming symbol consumed directly (bypass) is never stored.
            nxt_v <= 1'b1;
            nxt   <= in_data;
        end
    end

    assign in_ready  = !nxt_v;
    assign held      = nxt_v;
    assign out_valid = nxt_v || in_valid;
    assign out_data  = nxt_v ? nxt : in_data;

endmodule

// File: rtl/qpsk_nco_sched.sv
// qpsk_nco_sched: QPSK symbol scheduler / configurator for the carrier NCO.
//   clk, reset              clock, async active-high reset
//   run                     1 = transmit, 0 = stop at next symbol boundary
//   cfg_we/cfg_phi_inc/cfg_sps  configuration write (sps 0 treated as 1)
//   sym_valid/sym_data/sym_ready  symbol handshake from the packer
//   nco_clken/nco_phi_inc/nco_phase_mod  NCO controls
//   nco_out_valid           NCO pipeline warm-up indication
//   sym_strobe              pulse coincident with a new nco_phase_mod
//   underrun                sticky: boundary with no symbol available
//   busy                    FSM not idle
module qpsk_nco_sched
    import qpsk_pkg::*;
#(
    parameter int unsigned          APR         = 32,
    parameter int unsigned          APRP        = QPSK_APRP,
    parameter int unsigned          SPS_W       = 16,
    parameter logic [APR-1:0]       DEF_PHI_INC = 32'h0CCC_CCCD,
    parameter logic [APRP-1:0]      PHASE_OFS   = QPSK_PHASE_OFS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             cfg_we,
    input  logic [APR-1:0]   cfg_phi_inc,
    input  logic [SPS_W-1:0] cfg_sps,
    input  logic             sym_valid,
    input  logic [1:0]       sym_data,
    output logic             sym_ready,
    output logic             nco_clken,
    output logic [APR-1:0]   nco_phi_inc,
    output logic [APRP-1:0]  nco_phase_mod,
    input  logic             nco_out_valid,
    output logic             sym_strobe,
    output logic             underrun,
    output logic             busy
);

    localparam logic [SPS_W-1:0] SPS_ONE = {{(SPS_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [SPS_W-1:0] sps_reg;
    logic [SPS_W-1:0] active_sps;
    logic [SPS_W-1:0] counter;

    logic             boundary;
    logic             take;
    logic             held;
    logic             avail;
    logic [1:0]       sym_sel;
    logic [SPS_W-1:0] sps_eff;
    logic [APRP-1:0]  phase_new;

    qpsk_sym_skid u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (sym_valid),
        .in_data   (sym_data),
        .in_ready  (sym_ready),
        .take      (take),
        .held      (held),
        .out_valid (avail),
        .out_data  (sym_sel)
    );

    always_comb begin
        boundary  = (counter == active_sps - SPS_ONE);
        sps_eff   = (sps_reg == '0) ? SPS_ONE : sps_reg;
        phase_new = {gray_decode(sym_sel), {(APRP-2){1'b0}}} + PHASE_OFS;
        take      = 1'b0;
        unique case (state)
            // Starting from idle needs a symbol already in the slot; no bypass.
            IDLE:    take = run && held;
            // Warm-up ignores run: the started symbol sequence keeps going.
            PRIME:   take = boundary && avail;
            RUN:     take = boundary && run && avail;
            default: take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            counter       <= '0;
            sps_reg       <= SPS_ONE;
            active_sps    <= SPS_ONE;
            nco_phi_inc   <= DEF_PHI_INC;
            nco_phase_mod <= '0;
            sym_strobe    <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            sym_strobe <= 1'b0;

            if (cfg_we) begin
                nco_phi_inc <= cfg_phi_inc;
                sps_reg     <= cfg_sps;
            end

            if (take) begin
                nco_phase_mod <= phase_new;
                sym_strobe    <= 1'b1;
                active_sps    <= sps_eff;
            end

            unique case (state)
                IDLE: begin
                    counter <= '0;
                    if (take) begin
                        state <= PRIME;
                    end
                end
                PRIME: begin
                    counter <= boundary ? '0 : counter + SPS_ONE;
                    if (boundary && !avail) begin
                        underrun <= 1'b1;
                    end
                    if (nco_out_valid) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    counter <= boundary ? '0 : counter + SPS_ONE;
                    if (boundary) begin
                        if (!run) begin
                            state <= IDLE;
                        end else if (!avail) begin
                            underrun <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign nco_clken = (state != IDLE);
    assign busy      = (state != IDLE);

endmodule

// File: doc/qpsk_nco_sched.md
Name: qpsk_nco_sched

Overview:
- Symbol scheduler and configurator for the QPSK carrier NCO (14-bit phase-modulation input, 32-bit phase-increment input, clken, out_valid).
- Accepts 2-bit QPSK symbols over a valid/ready handshake and Gray-maps each one to a quadrant phase offset.
- Holds each symbol on the NCO phase_mod_i for a programmable number of samples, drives the NCO clken and phi_inc_i, and flags underruns.
- Sits between the bit-to-symbol packer and the NCO instance in the QPSK modulator.

Parameters:
- APR, 32, phase-increment width (NCO phi_inc_i).
- APRP, 14, phase-modulation width (NCO phase_mod_i).
- SPS_W, 16, width of the samples-per-symbol setting.
- DEF_PHI_INC, 32'h0CCC_CCCD, phi_inc driven after reset.
- PHASE_OFS, 14'h0800, constant constellation rotation (pi/4 at APRP=14), added modulo 2^APRP.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- run  in  1  level; 1 = transmit, 0 = stop at next symbol boundary
- cfg_we  in  1  config write strobe
- cfg_phi_inc  in  APR  new carrier phase increment
- cfg_sps  in  SPS_W  samples per symbol; 0 treated as 1
- sym_valid  in  1  symbol offered
- sym_data  in  2  QPSK dibit
- sym_ready  out  1  scheduler can accept a symbol
- nco_clken  out  1  to NCO clken
- nco_phi_inc  out  APR  to NCO phi_inc_i
- nco_phase_mod  out  APRP  to NCO phase_mod_i
- nco_out_valid  in  1  from NCO out_valid
- sym_strobe  out  1  one-cycle pulse when a new symbol is applied to nco_phase_mod
- underrun  out  1  sticky; set when a boundary occurs with no symbol available
- busy  out  1  state != IDLE

Behaviour:
- Reset values: nco_clken=0, nco_phi_inc=DEF_PHI_INC, nco_phase_mod=0, sym_ready=1, sym_strobe=0, underrun=0, busy=0, sps_reg=1, counter=0, state=IDLE. Reset mid-operation returns to these values immediately and drops any held symbol.
- Config: on cfg_we, nco_phi_inc updates the next cycle in any state. The sps_reg shadow updates on cfg_we. The active sps is latched only when a symbol is loaded.
- Skid slot: one-entry holding register nxt/nxt_v. sym_ready = !nxt_v. A transfer occurs when sym_valid && sym_ready.
- Mapping: quadrant = Gray decode (00→0, 01→1, 11→2, 10→3). nco_phase_mod = (quadrant << (APRP-2)) + PHASE_OFS, truncated to APRP bits. Example at APRP=14: 00→0x0800, 01→0x1800, 11→0x2800, 10→0x3800.
- State IDLE:
  - nco_clken=0; counter held at 0.
  - If run && nxt_v: load symbol, pulse sym_strobe, latch active sps, go to PRIME.
- State PRIME:
  - nco_clken=1; counter counts as in RUN.
  - Stay until nco_out_valid=1, then go to RUN. nco_out_valid is used only here, for NCO pipeline warm-up.
- State RUN:
  - nco_clken=1; counter increments every cycle.
  - Boundary = counter == active_sps-1. At a boundary the counter wraps to 0, then:
    - If !run: go to IDLE, nco_clken=0 from the next cycle, nco_phase_mod holds its value.
    - Else if nxt_v: load nxt, clear nxt_v, pulse sym_strobe.
    - Else if sym_valid at that same cycle: bypass-load sym_data directly, pulse sym_strobe, no underrun.
    - Else: hold the previous phase and set underrun (sticky until reset).
- Boundaries in PRIME apply the same load/underrun rules; only the RUN-exit condition differs.
- Timing:
  - Symbol load to nco_phase_mod: 1 cycle (registered).
  - sym_strobe is coincident with the new nco_phase_mod value.
  - Each symbol lasts exactly active_sps clken cycles.
- run falling mid-symbol: the current symbol completes, then IDLE. A symbol already in nxt is retained for the next run.

Decomposition:
- Package qpsk_pkg:
  - state enum {IDLE, PRIME, RUN}
  - Gray-decode function
  - APRP / PHASE_OFS constants shared with the demodulator.
- One natural sub-module, qpsk_sym_skid: the one-entry holding register with bypass. Everything else is inline.

Test Plan:
- Reset then idle: no stimulus → nco_phi_inc=0x0CCCCCCD, nco_clken=0, sym_ready=1, nco_phase_mod=0.
- Basic run: cfg_sps=4, symbols 00,01,11,10 back-to-back, run=1.
  - nco_phase_mod steps 0x0800, 0x1800, 0x2800, 0x3800, each held exactly 4 cycles.
  - sym_strobe every 4 cycles; underrun=0.
- Underrun: cfg_sps=3, one symbol 01 then no more → phase holds 0x1800 past the 3rd cycle and underrun=1 at the first empty boundary.
- Bypass: nxt empty, sym_valid=1 exactly on the boundary cycle → symbol applied the next cycle, underrun stays 0.
- Stop and config: run drops at sample 1 of a 4-sample symbol.
  - nco_clken goes low after sample 3; busy=0.
  - cfg_phi_inc=0x10000000 mid-RUN appears on nco_phi_inc the next cycle.
  - cfg_sps=2 written mid-symbol takes effect on the next symbol only.
- Async reset asserted mid-RUN → all outputs at reset values in the same cycle; the held symbol is discarded.
